// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the fetch/loader requesters, the arbiter and the instruction memory.
// The master side is the requesters plus the memory; the slave side is the arbiter.
interface imem_port_arbiter_if;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;

  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [DW-1:0] l_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          fetch_stall;

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, fetch_stall
  );

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, fetch_stall
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Single-port instruction memory arbiter: fetch has priority, the loader is
// guaranteed a slot after STARVE_LIMIT consecutive fetch wins while it waits.
module imem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_port_arbiter_if.slave    bus
);
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned CLOGW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned CNT_W = (CLOGW > 3) ? CLOGW : 3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic {OWN_FETCH, OWN_LOADER} owner_e;

  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  owner_e           r_owner;
  logic [DW-1:0]    r_f_hold;
  logic [DW-1:0]    r_l_hold;

  logic             w_force;
  logic             w_f_gnt;
  logic             w_l_gnt;
  logic             w_f_rvalid;
  logic             w_l_rvalid;
  logic             w_mem_we;
  logic [AW-1:0]    w_mem_addr;
  logic [DW-1:0]    w_mem_wdata;

  // Grant decision; everything is suppressed while reset is held.
  always_comb begin
    w_force     = 1'b0;
    w_f_gnt     = 1'b0;
    w_l_gnt     = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (!reset) begin
      w_force = bus.l_req && (r_cnt == CNT_MAX);
      w_f_gnt = bus.f_req && !w_force;
      w_l_gnt = bus.l_req && !w_f_gnt;
      if (w_f_gnt) begin
        w_mem_addr = bus.f_addr;
      end else if (w_l_gnt) begin
        w_mem_addr = bus.l_addr;
        w_mem_we   = bus.l_we;
        if (bus.l_we) begin
          w_mem_wdata = bus.l_wdata;
        end
      end
    end
  end

  // Consecutive fetch wins while the loader waits; saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_l_gnt || !bus.l_req) begin
      r_cnt <= '0;
    end else if (w_f_gnt && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Read-owner tracking and hold registers for the returned data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend   <= 1'b0;
      r_owner  <= OWN_FETCH;
      r_f_hold <= '0;
      r_l_hold <= '0;
    end else begin
      r_pend  <= w_f_gnt || (w_l_gnt && !bus.l_we);
      r_owner <= w_l_gnt ? OWN_LOADER : OWN_FETCH;
      if (w_f_rvalid) begin
        r_f_hold <= bus.mem_rdata;
      end
      if (w_l_rvalid) begin
        r_l_hold <= bus.mem_rdata;
      end
    end
  end

  assign w_f_rvalid = !reset && r_pend && (r_owner == OWN_FETCH);
  assign w_l_rvalid = !reset && r_pend && (r_owner == OWN_LOADER);

  assign bus.f_gnt       = w_f_gnt;
  assign bus.l_gnt       = w_l_gnt;
  assign bus.f_rvalid    = w_f_rvalid;
  assign bus.l_rvalid    = w_l_rvalid;
  assign bus.f_rdata     = reset ? '0 : (w_f_rvalid ? bus.mem_rdata : r_f_hold);
  assign bus.l_rdata     = reset ? '0 : (w_l_rvalid ? bus.mem_rdata : r_l_hold);
  assign bus.mem_en      = w_f_gnt || w_l_gnt;
  assign bus.mem_we      = w_mem_we;
  assign bus.mem_addr    = w_mem_addr;
  assign bus.mem_wdata   = w_mem_wdata;
  assign bus.fetch_stall = !reset && bus.f_req && !w_f_gnt;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a cycle-level reference model and
// a synchronous memory model standing in for the instruction RAM.
module tb_imem_port_arbiter;
  localparam int unsigned LIMIT = 4;

  logic clk;
  logic reset;
  imem_port_arbiter_if bus ();

  imem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  // Reference state: pending return, held data, loader wait length.
  logic        m_pend;
  logic        m_pend_l;
  logic [31:0] m_pend_data;
  logic [31:0] m_f_hold;
  logic [31:0] m_l_hold;
  int          m_waits;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous single-port memory: read data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the reference model, then advance the model.
  always @(negedge clk) begin
    logic        win_f, win_l, e_fv, e_lv;
    logic [31:0] e_frd, e_lrd, e_addr, e_wdata;
    win_f = 1'b0; win_l = 1'b0; e_fv = 1'b0; e_lv = 1'b0;
    e_frd = '0; e_lrd = '0; e_addr = '0; e_wdata = '0;
    if (!reset) begin
      e_fv  = m_pend && !m_pend_l;
      e_lv  = m_pend && m_pend_l;
      e_frd = e_fv ? m_pend_data : m_f_hold;
      e_lrd = e_lv ? m_pend_data : m_l_hold;
      if (bus.l_req && m_waits >= int'(LIMIT)) win_l = 1'b1;
      else if (bus.f_req)                     win_f = 1'b1;
      else if (bus.l_req)                     win_l = 1'b1;
      if (win_f) e_addr = 32'(bus.f_addr);
      if (win_l) e_addr = 32'(bus.l_addr);
      if (win_l && bus.l_we) e_wdata = bus.l_wdata;
    end
    chk("f_gnt",       32'(bus.f_gnt),       32'(win_f));
    chk("l_gnt",       32'(bus.l_gnt),       32'(win_l));
    chk("fetch_stall", 32'(bus.fetch_stall), 32'(!reset && bus.f_req && !win_f));
    chk("mem_en",      32'(bus.mem_en),      32'(win_f || win_l));
    chk("mem_we",      32'(bus.mem_we),      32'(win_l && bus.l_we));
    chk("mem_addr",    32'(bus.mem_addr),    e_addr);
    chk("mem_wdata",   bus.mem_wdata,        e_wdata);
    chk("f_rvalid",    32'(bus.f_rvalid),    32'(e_fv));
    chk("l_rvalid",    32'(bus.l_rvalid),    32'(e_lv));
    chk("f_rdata",     bus.f_rdata,          e_frd);
    chk("l_rdata",     bus.l_rdata,          e_lrd);
    if (reset) begin
      m_pend = 1'b0; m_pend_l = 1'b0; m_pend_data = '0;
      m_f_hold = '0; m_l_hold = '0; m_waits = 0;
    end else begin
      m_f_hold = e_frd;
      m_l_hold = e_lrd;
      m_pend   = win_f || (win_l && !bus.l_we);
      m_pend_l = win_l;
      m_pend_data = ref_mem[e_addr[9:0]];
      if (win_l && bus.l_we) ref_mem[bus.l_addr] = bus.l_wdata;
      m_waits = (bus.l_req && win_f) ? m_waits + 1 : 0;
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;
  endtask

  initial begin
    logic [31:0] wr_data [4];
    wr_data[0] = 32'hDEAD0001; wr_data[1] = 32'h12345678;
    wr_data[2] = 32'h0F0F0F0F; wr_data[3] = 32'hFFFFFFFF;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = {16'hC0DE, 16'(i)};
      ref_mem[i] = {16'hC0DE, 16'(i)};
    end
    m_pend = 1'b0; m_pend_l = 1'b0; m_pend_data = '0;
    m_f_hold = '0; m_l_hold = '0; m_waits = 0;
    bus.mem_rdata = '0;
    idle_inputs();
    reset = 1'b1;
    // Requests during reset are ignored.
    bus.f_req = 1'b1; bus.f_addr = 10'd3; bus.l_req = 1'b1;
    nxt(); nxt();
    mid();
    chk("rst_f_gnt",  32'(bus.f_gnt),       32'd0);
    chk("rst_stall",  32'(bus.fetch_stall), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en),      32'd0);
    nxt();
    reset = 1'b0;
    idle_inputs();

    // Fetch-only stream of words 0,1,2.
    bus.f_req = 1'b1; bus.f_addr = 10'd0;
    mid(); chk("fo_gnt0", 32'(bus.f_gnt), 32'd1);
    nxt(); bus.f_addr = 10'd1;
    mid(); chk("fo_data0", bus.f_rdata, 32'hC0DE0000);
    nxt(); bus.f_addr = 10'd2;
    mid(); chk("fo_data1", bus.f_rdata, 32'hC0DE0001);
    nxt(); bus.f_req = 1'b0;
    mid(); chk("fo_data2", bus.f_rdata, 32'hC0DE0002);
    nxt();

    // Starvation: four fetch wins, then the loader is forced in.
    bus.f_req = 1'b1; bus.f_addr = 10'd4; bus.l_req = 1'b1; bus.l_addr = 10'd7;
    for (int i = 0; i < 4; i++) begin
      mid(); chk("sv_fgnt", 32'(bus.f_gnt), 32'd1);
      nxt();
    end
    mid(); chk("sv_lgnt", 32'(bus.l_gnt), 32'd1); chk("sv_stall", 32'(bus.fetch_stall), 32'd1);
    nxt(); bus.l_req = 1'b0;
    mid(); chk("sv_fgnt_again", 32'(bus.f_gnt), 32'd1); chk("sv_ldata", bus.l_rdata, 32'hC0DE0007);
    nxt(); idle_inputs();
    nxt();

    // Loader write followed immediately by a fetch of the same word.
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 10'h010; bus.l_wdata = 32'h2008000A;
    nxt(); idle_inputs(); bus.f_req = 1'b1; bus.f_addr = 10'h010;
    nxt(); bus.f_req = 1'b0;
    mid(); chk("wf_data", bus.f_rdata, 32'h2008000A); chk("wf_lrv", 32'(bus.l_rvalid), 32'd0);
    nxt();

    // Interleaved fetch/loader reads.
    bus.f_req = 1'b1; bus.f_addr = 10'h005;
    nxt(); bus.f_req = 1'b0; bus.l_req = 1'b1; bus.l_addr = 10'h006;
    mid(); chk("il_fdata", bus.f_rdata, 32'hC0DE0005);
    nxt(); idle_inputs();
    mid(); chk("il_ldata", bus.l_rdata, 32'hC0DE0006); chk("il_frv", 32'(bus.f_rvalid), 32'd0);
    nxt();

    // Back-to-back loader writes, then back-to-back fetches of them.
    for (int i = 0; i < 4; i++) begin
      bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 10'(10'h020 + i); bus.l_wdata = wr_data[i];
      nxt();
    end
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      bus.f_req = (i < 4); bus.f_addr = 10'(10'h020 + i);
      if (i > 0) begin mid(); chk("bb_data", bus.f_rdata, wr_data[i-1]); end
      nxt();
    end
    idle_inputs();

    // Reset right after a fetch grant: the return is dropped.
    bus.f_req = 1'b1; bus.f_addr = 10'd9;
    nxt(); reset = 1'b1;
    mid(); chk("rm_frv", 32'(bus.f_rvalid), 32'd0); chk("rm_frd", bus.f_rdata, 32'd0);
    nxt(); reset = 1'b0; bus.f_req = 1'b0;
    mid(); chk("rm_frv_after", 32'(bus.f_rvalid), 32'd0);
    nxt();
    // Counter restarted from zero: loader forced on the fifth cycle again.
    bus.f_req = 1'b1; bus.f_addr = 10'd1; bus.l_req = 1'b1; bus.l_addr = 10'd2;
    for (int i = 0; i < 4; i++) nxt();
    mid(); chk("rm_lgnt", 32'(bus.l_gnt), 32'd1);
    nxt(); bus.l_req = 1'b0;
    nxt(); idle_inputs();
    mid(); chk("rm_fdata", bus.f_rdata, 32'hC0DE0001);
    nxt();

    // Idle: data outputs hold.
    for (int i = 0; i < 10; i++) nxt();
    mid();
    chk("id_mem_en", 32'(bus.mem_en), 32'd0);
    chk("id_fhold",  bus.f_rdata, 32'hC0DE0001);
    chk("id_lhold",  bus.l_rdata, 32'hC0DE0002);
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imem_port_arbiter.md
IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4: the number of consecutive cycles the fetch requester may win while the loader waits before the loader is forced a grant.
REQ-002 The block SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-003 The block SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-004 The block SHALL have port f_req, input, 1: fetch-stage read request.
REQ-005 The block SHALL have port f_addr, input, 10: fetch word address, byte address bits [11:2].
REQ-006 The block SHALL have port f_gnt, output, 1: fetch request accepted this cycle.
REQ-007 The block SHALL have ports f_rvalid, output, 1, and f_rdata, output, 32: fetch read data, valid one cycle after f_gnt.
REQ-008 The block SHALL have ports l_req, input, 1; l_we, input, 1; l_addr, input, 10; l_wdata, input, 32: program-loader/debug access (l_we=1 write, l_we=0 read).
REQ-009 The block SHALL have ports l_gnt, output, 1; l_rvalid, output, 1; l_rdata, output, 32: loader accept and read return.
REQ-010 The block SHALL have ports mem_en, mem_we, output, 1; mem_addr, output, 10; mem_wdata, output, 32; mem_rdata, input, 32: single-port synchronous memory, read data valid the cycle after mem_en with mem_we=0.
REQ-011 The block SHALL have port fetch_stall, output, 1: f_req high but not granted this cycle.

Function
REQ-012 At most one of f_gnt, l_gnt SHALL be high in any cycle; a grant is combinational in the cycle of the request; there is no back-pressure on read returns.
REQ-013 Default priority SHALL be fetch: if f_req and l_req are both high and the starvation counter is below STARVE_LIMIT, f_gnt=1.
REQ-014 Starvation counter (3 bits min.) SHALL increment on each cycle with l_req=1 and f_gnt=1, clear on any l_gnt or any cycle with l_req=0, and saturate at STARVE_LIMIT.
REQ-015 When counter==STARVE_LIMIT and l_req=1, l_gnt=1 regardless of f_req; fetch_stall=1 that cycle.
REQ-016 On a grant, mem_en=1, mem_addr/mem_we/mem_wdata SHALL come from the winner in the same cycle; fetch grants force mem_we=0.
REQ-017 Read-owner register SHALL record {pending, owner} on each read grant; the next cycle the owner's rvalid=1 with rdata=mem_rdata; write grants set no pending.
REQ-018 Back-to-back grants SHALL be accepted every cycle (throughput 1 access/cycle); a return and a new grant in the same cycle are independent.
REQ-019 f_rdata/l_rdata SHALL hold their last returned value when the corresponding rvalid=0.
REQ-020 Loader write to address A in cycle N followed by fetch read of A in cycle N+1 SHALL return the written data in cycle N+2.
REQ-021 With no request, mem_en=0, mem_we=0, and address/wdata outputs SHALL be 0.
REQ-022 fetch_stall SHALL equal f_req & ~f_gnt.

Reset
REQ-023 While reset=1: f_gnt, l_gnt, f_rvalid, l_rvalid, mem_en, mem_we, fetch_stall=0; counter=0; pending cleared; f_rdata, l_rdata=0.
REQ-024 A read granted in the cycle reset is sampled SHALL produce no rvalid afterwards.
REQ-025 Requests present during reset SHALL be ignored; arbitration resumes the first cycle after reset deasserts.

Verification
REQ-026 Fetch only: f_req=1 with f_addr=0,1,2 on consecutive cycles, memory preloaded -> f_gnt=1 each cycle, f_rvalid=1 one cycle later with words 0,1,2 in order.
REQ-027 Starvation: f_req and l_req held high, STARVE_LIMIT=4 -> f_gnt for 4 cycles, l_gnt in the 5th with fetch_stall=1, then f_gnt again.
REQ-028 Write-then-fetch: l_we=1, l_addr=0x010, l_wdata=0x2008000A in cycle N; f_req, f_addr=0x010 in cycle N+1 -> f_rvalid=1, f_rdata=0x2008000A in N+2; no l_rvalid.
REQ-029 Interleaved reads: fetch read of 0x005, then loader read of 0x006 -> f_rvalid then l_rvalid on successive cycles, each with correct data, never both high together.
REQ-030 Reset mid-operation: fetch read granted, reset=1 next cycle -> f_rvalid stays 0, all outputs 0, counter 0, normal grants resume after reset drops.
REQ-031 Idle: no requests for 10 cycles -> mem_en=0, fetch_stall=0, rdata outputs hold their last values.
